tick_divider: RTL and testbench

- Divides the system clock into a periodic single-cycle `enable` strobe.
- The traffic-light controller uses the strobe as its timing tick, e.g. 1 Hz from 50 MHz.
- Purely sequential: free-running counter plus registered strobe output.
- No data path and no handshake.

---
 rtl/tick_divider_pkg.sv | 18 +
 rtl/tick_divider_mod_counter.sv | 40 ++++
 rtl/tick_divider.sv | 64 ++++++
 tb/tb_tick_divider.sv | 104 ++++++++++
 4 files changed

// File: rtl/tick_divider_pkg.sv
// -----------------------------------------------------------------------------
// tick_divider_pkg
// Shared constants and helpers for the tick divider.
//   DEFAULT_DIV : production divide ratio (1 Hz tick from a 50 MHz clock)
//   SIM_DIV     : short divide ratio used by simulation benches
//   cnt_width() : counter width for a given divide ratio, never below 1 bit
// -----------------------------------------------------------------------------
package tick_divider_pkg;

    localparam int unsigned DEFAULT_DIV = 50_000_000;
    localparam int unsigned SIM_DIV     = 4;

    // A divide ratio of 1 still needs a 1-bit counter so the port exists.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div <= 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/tick_divider_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-N up-counter with asynchronous active-low clear and a registered
// terminal-count flag.
//   clock   : rising-edge clock
//   clear_n : asynchronous active-low clear (count and tc to 0)
//   count   : current count, 0 .. N-1
//   tc      : high for the one cycle following the edge that saw count == N-1
// -----------------------------------------------------------------------------
module mod_counter
    import tick_divider_pkg::*;
#(
    parameter int unsigned N = SIM_DIV,
    parameter int unsigned W = cnt_width(N)
) (
    input  logic         clock,
    input  logic         clear_n,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Wrap uses >= so an out-of-range count (e.g. after an upset) returns to 0
    // on the next edge; the strobe only fires on the exact terminal value.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            if (count >= LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            tc <= (count == LAST);
        end
    end

endmodule

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Divides the system clock into a single-cycle enable strobe every DIV clocks.
//   clock       : system clock, rising edge
//   timer_reset : asynchronous active-low reset
//   enable      : registered strobe, high one clock in every DIV clocks
//   square      : (only with TICK_DIVIDER_SQUARE_EN) registered ~50% duty
//                 signal, high while the counter is below DIV/2
// Optional feature macro: TICK_DIVIDER_SQUARE_EN
// -----------------------------------------------------------------------------
module tick_divider
    import tick_divider_pkg::*;
#(
    parameter int unsigned DIV = DEFAULT_DIV
) (
    input  logic clock,
    input  logic timer_reset,
    output logic enable
`ifdef TICK_DIVIDER_SQUARE_EN
    ,
    output logic square
`endif
);

    localparam int unsigned CNT_W = cnt_width(DIV);

    if (DIV == 0) begin : g_div_check
        $error("tick_divider: DIV must be at least 1");
    end

    logic [CNT_W-1:0] count;

    // enable comes straight from the counter's terminal-count flop.
    mod_counter #(
        .N (DIV),
        .W (CNT_W)
    ) u_cnt (
        .clock   (clock),
        .clear_n (timer_reset),
        .count   (count),
        .tc      (enable)
    );

`ifdef TICK_DIVIDER_SQUARE_EN
    localparam int unsigned HALF = DIV / 2;

    logic [31:0] count_ext;
    assign count_ext = 32'(count);

    // Stage p1: square registered from the current count, so it lags the
    // counter by one edge just like enable does; DIV=1 gives HALF=0, always low.
    always_ff @(posedge clock or negedge timer_reset) begin
        if (!timer_reset) begin
            square <= 1'b0;
        end else begin
            square <= (count_ext < HALF);
        end
    end
`else
    logic unused_count;
    assign unused_count = ^count;
`endif

endmodule

// File: tb/tb_tick_divider.sv
module tb_tick_divider;
    import tick_divider_pkg::*;

    logic clock = 1'b0;
    logic timer_reset = 1'b1;
    logic en4, en1, en2, en5;
`ifdef TICK_DIVIDER_SQUARE_EN
    logic sq4, sq1, sq2, sq5;
`endif

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

`ifdef TICK_DIVIDER_SQUARE_EN
    tick_divider #(.DIV(SIM_DIV)) dut4 (.clock(clock), .timer_reset(timer_reset), .enable(en4), .square(sq4));
    tick_divider #(.DIV(1))       dut1 (.clock(clock), .timer_reset(timer_reset), .enable(en1), .square(sq1));
    tick_divider #(.DIV(2))       dut2 (.clock(clock), .timer_reset(timer_reset), .enable(en2), .square(sq2));
    tick_divider #(.DIV(5))       dut5 (.clock(clock), .timer_reset(timer_reset), .enable(en5), .square(sq5));
`else
    tick_divider #(.DIV(SIM_DIV)) dut4 (.clock(clock), .timer_reset(timer_reset), .enable(en4));
    tick_divider #(.DIV(1))       dut1 (.clock(clock), .timer_reset(timer_reset), .enable(en1));
    tick_divider #(.DIV(2))       dut2 (.clock(clock), .timer_reset(timer_reset), .enable(en2));
    tick_divider #(.DIV(5))       dut5 (.clock(clock), .timer_reset(timer_reset), .enable(en5));
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset held from t=1 to t=440 (439 ns), checked on every falling edge.
        #1 timer_reset = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            check($sformatf("rst en4 %0d", i), en4, 0);
            check($sformatf("rst cnt4 %0d", i), dut4.u_cnt.count, 0);
            check($sformatf("rst en1 %0d", i), en1, 0);
            check($sformatf("rst en5 %0d", i), en5, 0);
`ifdef TICK_DIVIDER_SQUARE_EN
            check($sformatf("rst sq5 %0d", i), sq5, 0);
`endif
        end
        timer_reset = 1'b1;

        // Edge k after release: DIV=4 high on k%4==0, DIV=1 always,
        // DIV=2 on even edges, DIV=5 on k%5==0.
        for (int k = 1; k <= 16; k++) begin
            step();
            check($sformatf("run en4 k=%0d", k), en4, (k % 4 == 0));
            check($sformatf("run en1 k=%0d", k), en1, 1);
            check($sformatf("run en2 k=%0d", k), en2, (k % 2 == 0));
            check($sformatf("run en5 k=%0d", k), en5, (k % 5 == 0));
`ifdef TICK_DIVIDER_SQUARE_EN
            // Count before edge k is (k-1)%5; square high when that is < 2.
            check($sformatf("run sq5 k=%0d", k), sq5, ((k - 1) % 5 < 2));
            check($sformatf("run sq1 k=%0d", k), sq1, 0);
`endif
        end

        // en4 is high here (k=16); pull reset mid-cycle, expect an immediate drop.
        #3 timer_reset = 1'b0;
        #1;
        check("async en4", en4, 0);
        check("async cnt4", dut4.u_cnt.count, 0);
        check("async en1", en1, 0);
        @(negedge clock);
        timer_reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("rel en4 k=%0d", k), en4, (k % 4 == 0));
            check($sformatf("rel en1 k=%0d", k), en1, 1);
            check($sformatf("rel en5 k=%0d", k), en5, (k % 5 == 0));
        end

        // Out-of-range count on the 3-bit DIV=5 counter must wrap to 0.
        @(negedge clock);
        force dut5.u_cnt.count = 3'd7;
        #1 release dut5.u_cnt.count;
        step();
        check("wrap cnt5", dut5.u_cnt.count, 0);
        check("wrap en5", en5, 0);
        for (int m = 1; m <= 6; m++) begin
            step();
            check($sformatf("post cnt5 m=%0d", m), dut5.u_cnt.count, m % 5);
            check($sformatf("post en5 m=%0d", m), en5, (m == 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
